// File: rtl/operand_demux_pkg.sv
// Shared definitions for the operand demultiplexer: slot select polarity and
// the state encoding formed by {b_loaded, a_loaded}.
package operand_demux_pkg;

    // Same polarity as the 2:1 operand selector in the arithmetic unit.
    localparam logic SelA = 1'b0;
    localparam logic SelB = 1'b1;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StHaveA = 2'b01,
        StHaveB = 2'b10,
        StFull  = 2'b11
    } state_e;

endpackage

// File: rtl/operand_demux_slot.sv
// One operand slot: data register plus a loaded flag. Clear drops only the
// flag so the last operand value stays visible.
module operand_demux_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o,
    output logic             loaded_o
);

    logic [Width-1:0] data_q, data_d;
    logic             loaded_q, loaded_d;

    always_comb begin
        data_d   = data_q;
        loaded_d = loaded_q;
        if (clear_i) begin
            loaded_d = 1'b0;
        end else if (load_i) begin
            data_d   = d_i;
            loaded_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            loaded_q <= loaded_d;
        end
    end

    assign q_o      = data_q;
    assign loaded_o = loaded_q;

endmodule

// File: rtl/operand_demux.sv
// Registered 1-to-2 operand demultiplexer: steers a byte stream into operand
// slots A/B and hands the completed pair to the arithmetic core.
module operand_demux
    import operand_demux_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic             auto_seq_i,
    input  logic             a0_i,
    output logic [Width-1:0] a_o,
    output logic [Width-1:0] b_o,
    output logic             a_loaded_o,
    output logic             b_loaded_o,
    output logic             pair_valid_o,
    input  logic             pair_ready_i,
    output logic [7:0]       pair_count_o
);

    logic   a_loaded, b_loaded;
    logic   target;
    logic   din_ready;
    logic   accept, consume;
    logic   load_a, load_b;
    state_e state;
    logic [7:0] pair_count_q, pair_count_d;

    assign state = state_e'({b_loaded, a_loaded});

    // Auto mode fills A first, then B; also covers a mid-pair switch into auto.
    assign target = auto_seq_i ? (a_loaded ? SelB : SelA) : a0_i;

    always_comb begin
        din_ready = 1'b0;
        if (!rst_i) begin
            unique case (state)
                StEmpty: din_ready = 1'b1;
                StHaveA: din_ready = (target == SelB);
                StHaveB: din_ready = (target == SelA);
                StFull:  din_ready = 1'b0;
                default: din_ready = 1'b0;
            endcase
        end
    end

    assign accept  = din_valid_i && din_ready;
    assign consume = (state == StFull) && pair_ready_i;
    assign load_a  = accept && (target == SelA);
    assign load_b  = accept && (target == SelB);

    operand_demux_slot #(
        .Width (Width)
    ) u_slot_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load_a),
        .clear_i  (consume),
        .d_i      (din_i),
        .q_o      (a_o),
        .loaded_o (a_loaded)
    );

    operand_demux_slot #(
        .Width (Width)
    ) u_slot_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load_b),
        .clear_i  (consume),
        .d_i      (din_i),
        .q_o      (b_o),
        .loaded_o (b_loaded)
    );

    always_comb begin
        pair_count_d = pair_count_q;
        if (consume) begin
            pair_count_d = pair_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pair_count_q <= 8'd0;
        end else begin
            pair_count_q <= pair_count_d;
        end
    end

    assign din_ready_o  = din_ready;
    assign a_loaded_o   = a_loaded;
    assign b_loaded_o   = b_loaded;
    assign pair_valid_o = (state == StFull);
    assign pair_count_o = pair_count_q;

endmodule

// File: tb/tb_operand_demux.sv
// Directed self-checking bench for operand_demux; each task covers one scenario
// with hand-computed expected values.
module tb_operand_demux;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       auto_seq;
    logic       a0;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       a_loaded;
    logic       b_loaded;
    logic       pair_valid;
    logic       pair_ready;
    logic [7:0] pair_count;

    int n_pass  = 0;
    int n_total = 0;

    operand_demux #(
        .Width (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .din_ready_o  (din_ready),
        .auto_seq_i   (auto_seq),
        .a0_i         (a0),
        .a_o          (a_q),
        .b_o          (b_q),
        .a_loaded_o   (a_loaded),
        .b_loaded_o   (b_loaded),
        .pair_valid_o (pair_valid),
        .pair_ready_i (pair_ready),
        .pair_count_o (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        n_total++;
        if ({a_q, b_q, a_loaded, b_loaded, pair_valid, pair_count, din_ready} !== 27'd0) begin
            $display("FAIL reset_state: got A=%h B=%h al=%b bl=%b pv=%b cnt=%0d rdy=%b, want all 0",
                     a_q, b_q, a_loaded, b_loaded, pair_valid, pair_count, din_ready);
        end else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (din_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", din_ready);
        else n_pass++;
    endtask

    task automatic test_auto_pair();
        auto_seq  = 1'b1;
        din_valid = 1'b1;
        din       = 8'h12;
        cyc();
        din = 8'h34;
        #1;
        n_total++;
        if (a_q !== 8'h12 || a_loaded !== 1'b1 || pair_valid !== 1'b0)
            $display("FAIL auto_first: got A=%h al=%b pv=%b want A=12 al=1 pv=0",
                     a_q, a_loaded, pair_valid);
        else n_pass++;
        cyc();
        din_valid = 1'b0;
        #1;
        n_total++;
        if (a_q !== 8'h12 || b_q !== 8'h34 || pair_valid !== 1'b1 || din_ready !== 1'b0)
            $display("FAIL auto_pair: got A=%h B=%h pv=%b rdy=%b want A=12 B=34 pv=1 rdy=0",
                     a_q, b_q, pair_valid, din_ready);
        else n_pass++;
        pair_ready = 1'b1;
        cyc();
        pair_ready = 1'b0;
        #1;
        n_total++;
        if (a_loaded !== 1'b0 || b_loaded !== 1'b0 || pair_count !== 8'd1 ||
            din_ready !== 1'b1 || a_q !== 8'h12 || b_q !== 8'h34)
            $display("FAIL auto_consume: got al=%b bl=%b cnt=%0d rdy=%b A=%h B=%h want 0 0 1 1 12 34",
                     a_loaded, b_loaded, pair_count, din_ready, a_q, b_q);
        else n_pass++;
    endtask

    task automatic test_explicit_stall();
        auto_seq  = 1'b0;
        a0        = 1'b1;
        din       = 8'h55;
        din_valid = 1'b1;
        cyc();
        din = 8'h66;
        #1;
        n_total++;
        if (b_q !== 8'h55 || b_loaded !== 1'b1 || a_loaded !== 1'b0 || din_ready !== 1'b0)
            $display("FAIL explicit_b_stall: got B=%h bl=%b al=%b rdy=%b want B=55 bl=1 al=0 rdy=0",
                     b_q, b_loaded, a_loaded, din_ready);
        else n_pass++;
        cyc();
        n_total++;
        if (b_q !== 8'h55 || a_loaded !== 1'b0 || pair_valid !== 1'b0)
            $display("FAIL explicit_hold: got B=%h al=%b pv=%b want B=55 al=0 pv=0",
                     b_q, a_loaded, pair_valid);
        else n_pass++;
        a0 = 1'b0;
        #1;
        n_total++;
        if (din_ready !== 1'b1) $display("FAIL explicit_switch_ready: got %b want 1", din_ready);
        else n_pass++;
        cyc();
        din_valid = 1'b0;
        #1;
        n_total++;
        if (a_q !== 8'h66 || b_q !== 8'h55 || pair_valid !== 1'b1)
            $display("FAIL explicit_pair: got A=%h B=%h pv=%b want A=66 B=55 pv=1",
                     a_q, b_q, pair_valid);
        else n_pass++;
        pair_ready = 1'b1;
        cyc();
        pair_ready = 1'b0;
        n_total++;
        if (pair_count !== 8'd2) $display("FAIL explicit_count: got %0d want 2", pair_count);
        else n_pass++;
    endtask

    task automatic test_full_hold();
        auto_seq  = 1'b1;
        din_valid = 1'b1;
        din       = 8'h10;
        cyc();
        din = 8'h20;
        cyc();
        din = 8'hFF;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (din_ready !== 1'b0 || a_q !== 8'h10 || b_q !== 8'h20 || pair_valid !== 1'b1)
                $display("FAIL full_hold[%0d]: got rdy=%b A=%h B=%h pv=%b want 0 10 20 1",
                         i, din_ready, a_q, b_q, pair_valid);
            else n_pass++;
            cyc();
        end
        pair_ready = 1'b1;
        cyc();
        pair_ready = 1'b0;
        din_valid  = 1'b0;
        cyc();
        n_total++;
        if (pair_count !== 8'd3 || pair_valid !== 1'b0 || a_q !== 8'h10 || b_q !== 8'h20)
            $display("FAIL full_consume_once: got cnt=%0d pv=%b A=%h B=%h want 3 0 10 20",
                     pair_count, pair_valid, a_q, b_q);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        auto_seq  = 1'b1;
        din_valid = 1'b1;
        din       = 8'hAA;
        cyc();
        din_valid = 1'b0;
        n_total++;
        if (a_q !== 8'hAA || a_loaded !== 1'b1)
            $display("FAIL midrst_load: got A=%h al=%b want AA 1", a_q, a_loaded);
        else n_pass++;
        rst = 1'b1;
        cyc();
        n_total++;
        if ({a_q, b_q, a_loaded, b_loaded, pair_valid, pair_count, din_ready} !== 27'd0)
            $display("FAIL midrst_clear: got A=%h B=%h al=%b bl=%b pv=%b cnt=%0d rdy=%b want all 0",
                     a_q, b_q, a_loaded, b_loaded, pair_valid, pair_count, din_ready);
        else n_pass++;
        rst       = 1'b0;
        din_valid = 1'b1;
        din       = 8'h01;
        cyc();
        din = 8'h02;
        cyc();
        din_valid = 1'b0;
        n_total++;
        if (a_q !== 8'h01 || b_q !== 8'h02 || pair_valid !== 1'b1)
            $display("FAIL midrst_reload: got A=%h B=%h pv=%b want 01 02 1", a_q, b_q, pair_valid);
        else n_pass++;
        pair_ready = 1'b1;
        cyc();
        pair_ready = 1'b0;
        n_total++;
        if (pair_count !== 8'd1) $display("FAIL midrst_count: got %0d want 1", pair_count);
        else n_pass++;
    endtask

    // Count is 1 on entry; 255 more pairs wrap it to 0, one more gives 1.
    task automatic test_wrap();
        auto_seq = 1'b1;
        for (int i = 0; i < 256; i++) begin
            din_valid = 1'b1;
            din       = i[7:0];
            cyc();
            din = ~i[7:0];
            cyc();
            din_valid  = 1'b0;
            pair_ready = 1'b1;
            cyc();
            pair_ready = 1'b0;
            if (i == 254) begin
                n_total++;
                if (pair_count !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", pair_count);
                else n_pass++;
            end
        end
        n_total++;
        if (pair_count !== 8'd1 || a_q !== 8'hFF || b_q !== 8'h00)
            $display("FAIL wrap_next: got cnt=%0d A=%h B=%h want 1 FF 00", pair_count, a_q, b_q);
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        auto_seq  = 1'b0;
        a0        = 1'b1;
        din_valid = 1'b1;
        din       = 8'h77;
        cyc();
        auto_seq = 1'b1;
        din      = 8'h88;
        #1;
        n_total++;
        if (din_ready !== 1'b1 || b_q !== 8'h77 || a_loaded !== 1'b0)
            $display("FAIL switch_ready: got rdy=%b B=%h al=%b want 1 77 0", din_ready, b_q, a_loaded);
        else n_pass++;
        cyc();
        din_valid = 1'b0;
        n_total++;
        if (a_q !== 8'h88 || b_q !== 8'h77 || pair_valid !== 1'b1)
            $display("FAIL switch_pair: got A=%h B=%h pv=%b want 88 77 1", a_q, b_q, pair_valid);
        else n_pass++;
    endtask

    initial begin
        rst        = 1'b1;
        din        = 8'h00;
        din_valid  = 1'b0;
        auto_seq   = 1'b1;
        a0         = 1'b0;
        pair_ready = 1'b0;
        test_reset();
        test_auto_pair();
        test_explicit_stall();
        test_full_hold();
        test_mid_reset();
        test_wrap();
        test_mode_switch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
